usb_ep0_desc_reader: RTL and testbench

//  EP0 control-transfer engine for GET_DESCRIPTOR. Decodes the 8-byte SETUP payload and reads the descriptor ROM byte by byte.

---
 rtl/usb_ep0_desc_reader.sv | 198 +++++++++++++++++++
 tb/tb_usb_ep0_desc_reader.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep0_desc_reader.sv
// rtl/usb_ep0_desc_reader.sv - EP0 GET_DESCRIPTOR control-transfer engine
// Optional feature macro: USB_DESC_STALL_EN (STALL unsupported requests and unknown descriptors).
module usb_ep0_desc_reader #(
    parameter int MAX_PKT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        setup_valid,
    input  logic [63:0] setup_data,
    input  logic        in_token,
    input  logic        out_status,
    input  logic        tx_ack,
    input  logic        tx_timeout,
    output logic [7:0]  desc_type,
    output logic [7:0]  desc_index,
    output logic [15:0] desc_req_len,
    output logic [15:0] desc_byte_index,
    input  logic [7:0]  desc_data,
    input  logic        desc_valid,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic        tx_zlp,
    output logic        tx_data1,
    output logic        stall,
    output logic        busy,
    output logic        done
);
    localparam int CW = $clog2(MAX_PKT + 1);
    localparam logic [CW-1:0] MAX_N = CW'(MAX_PKT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IN, S_FILL, S_SEND, S_WAIT_ACK, S_STALL_PEND
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    type_q, type_d, index_q, index_d;
    logic [15:0]   req_len_q, req_len_d, sent_q, sent_d;
    logic [CW-1:0] n_q, n_d, ptr_q, ptr_d;
    logic          toggle_q, toggle_d, complete_q, complete_d;
    logic          done_q, done_d, stall_q, stall_d;
    logic [7:0]    buf_q [2**CW];
    logic          buf_we;
    logic [15:0]   n_ext;
    logic          setup_ok, unknown_desc, last_beat;
    logic          unused_wIndex;

    assign unused_wIndex = ^setup_data[47:32];
    assign n_ext    = {{(16-CW){1'b0}}, n_q};
    assign setup_ok = ((setup_data[7:0] == 8'h80) || (setup_data[7:0] == 8'h81))
                      && (setup_data[15:8] == 8'h06);
    assign last_beat = (n_q == '0) || (ptr_q == n_q - ONE);

`ifdef USB_DESC_STALL_EN
    // Nothing readable at byte 0 of a non-empty request means the ROM has no such descriptor.
    assign unknown_desc = (n_q == '0) && (sent_q == 16'd0) && (req_len_q != 16'd0);
`else
    assign unknown_desc = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        index_d    = index_q;
        req_len_d  = req_len_q;
        sent_d     = sent_q;
        n_d        = n_q;
        ptr_d      = ptr_q;
        toggle_d   = toggle_q;
        complete_d = complete_q;
        done_d     = 1'b0;
        stall_d    = 1'b0;
        buf_we     = 1'b0;
        case (state_q)
            S_WAIT_IN: begin
                if (out_status) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (in_token && !complete_q) begin
                    n_d     = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if ((n_q == MAX_N) || !desc_valid) begin
                    if (unknown_desc) begin
                        stall_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ptr_d   = '0;
                        state_d = S_SEND;
                    end
                end else begin
                    buf_we = 1'b1;
                    n_d    = n_q + ONE;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (last_beat) state_d = S_WAIT_ACK;
                    else           ptr_d   = ptr_q + ONE;
                end
            end
            S_WAIT_ACK: begin
                if (tx_ack) begin
                    sent_d   = sent_q + n_ext;
                    toggle_d = ~toggle_q;
                    // With wLength==0 the ZLP just sent is itself the status stage.
                    if (req_len_q == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        complete_d = (sent_d == req_len_q) || (n_q != MAX_N);
                        state_d    = S_WAIT_IN;
                    end
                end else if (tx_timeout) begin
                    state_d = S_WAIT_IN;
                end
            end
            S_STALL_PEND: begin
                if (in_token) begin
                    stall_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
        if (setup_valid) begin
            done_d  = 1'b0;
            stall_d = 1'b0;
            if (setup_ok) begin
                type_d     = setup_data[31:24];
                index_d    = setup_data[23:16];
                req_len_d  = setup_data[63:48];
                sent_d     = 16'd0;
                n_d        = '0;
                ptr_d      = '0;
                toggle_d   = 1'b1;
                complete_d = 1'b0;
                state_d    = S_WAIT_IN;
            end else begin
`ifdef USB_DESC_STALL_EN
                state_d = S_STALL_PEND;
`else
                state_d = S_IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            type_q     <= 8'd0;
            index_q    <= 8'd0;
            req_len_q  <= 16'd0;
            sent_q     <= 16'd0;
            n_q        <= '0;
            ptr_q      <= '0;
            toggle_q   <= 1'b1;
            complete_q <= 1'b0;
            done_q     <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            index_q    <= index_d;
            req_len_q  <= req_len_d;
            sent_q     <= sent_d;
            n_q        <= n_d;
            ptr_q      <= ptr_d;
            toggle_q   <= toggle_d;
            complete_q <= complete_d;
            done_q     <= done_d;
            stall_q    <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[n_q] <= desc_data;
    end

    assign desc_type       = type_q;
    assign desc_index      = index_q;
    assign desc_req_len    = req_len_q;
    assign desc_byte_index = sent_q + n_ext;
    assign tx_valid        = (state_q == S_SEND) && !rst;
    assign tx_data         = (state_q == S_SEND) ? buf_q[ptr_q] : 8'd0;
    assign tx_last         = (state_q == S_SEND) && last_beat;
    assign tx_zlp          = (state_q == S_SEND) && (n_q == '0);
    assign tx_data1        = (state_q == S_SEND) && toggle_q;
    assign stall           = stall_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_usb_ep0_desc_reader.sv
// tb/tb_usb_ep0_desc_reader.sv - directed self-checking bench for usb_ep0_desc_reader
// Honours USB_DESC_STALL_EN the same way as the design.
module tb_usb_ep0_desc_reader;
    logic        clk = 1'b0;
    logic        rst, setup_valid, in_token, out_status, tx_ack, tx_timeout, tx_ready;
    logic [63:0] setup_data;
    logic [7:0]  desc_type, desc_index, desc_data, tx_data;
    logic [15:0] desc_req_len, desc_byte_index;
    logic        desc_valid, tx_valid, tx_last, tx_zlp, tx_data1, stall, busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rom_lim;

    logic [7:0] pkt [64];
    int   pkt_len;
    logic pkt_got, pkt_d1, pkt_zlp, pkt_stable;
    logic saw_valid, saw_stall, saw_done;

    localparam logic [7:0] DEV [18] = '{8'h12, 8'h01, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08,
                                        8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02,
                                        8'h03, 8'h01};

    always #5 clk = ~clk;

    usb_ep0_desc_reader #(.MAX_PKT(8)) dut (
        .clk(clk), .rst(rst), .setup_valid(setup_valid), .setup_data(setup_data),
        .in_token(in_token), .out_status(out_status), .tx_ack(tx_ack), .tx_timeout(tx_timeout),
        .desc_type(desc_type), .desc_index(desc_index), .desc_req_len(desc_req_len),
        .desc_byte_index(desc_byte_index), .desc_data(desc_data), .desc_valid(desc_valid),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .tx_zlp(tx_zlp), .tx_data1(tx_data1), .stall(stall), .busy(busy), .done(done)
    );

    // Descriptor ROM model: 1=device(18B), 2=config(34B), 3=stub(16B), others absent.
    function automatic int rom_len(input logic [7:0] t);
        case (t)
            8'h01:   return 18;
            8'h02:   return 34;
            8'h03:   return 16;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] rom_byte(input logic [7:0] t, input int i);
        case (t)
            8'h01:   return (i < 18) ? DEV[i[4:0]] : 8'h00;
            8'h02:   return 8'h40 + i[7:0];
            8'h03:   return 8'h80 + i[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        rom_lim = rom_len(desc_type);
        if (int'(desc_req_len) < rom_lim) rom_lim = int'(desc_req_len);
        desc_valid = int'(desc_byte_index) < rom_lim;
        desc_data  = desc_valid ? rom_byte(desc_type, int'(desc_byte_index)) : 8'h00;
    end

    function automatic logic pkt_match(input logic [7:0] t, input int start);
        for (int k = 0; k < pkt_len && k < 64; k++)
            if (pkt[k] !== rom_byte(t, start + k)) return 1'b0;
        return pkt_stable;
    endfunction

    task automatic do_setup(input logic [7:0] bm, input logic [7:0] breq, input logic [7:0] t,
                            input logic [7:0] idx, input logic [15:0] wlen);
        setup_data  = {wlen, 16'h0000, t, idx, breq, bm};
        setup_valid = 1'b1;
        @(negedge clk);
        setup_valid = 1'b0;
    endtask

    task automatic pulse_in();
        in_token = 1'b1; @(negedge clk); in_token = 1'b0;
    endtask

    task automatic pulse_ack();
        tx_ack = 1'b1; @(negedge clk); tx_ack = 1'b0;
    endtask

    task automatic pulse_timeout();
        tx_timeout = 1'b1; @(negedge clk); tx_timeout = 1'b0;
    endtask

    task automatic pulse_out();
        out_status = 1'b1; @(negedge clk); out_status = 1'b0;
    endtask

    // Collect one packet with a throttled ready (2 of every 3 cycles).
    task automatic recv_pkt();
        pkt_len = 0; pkt_got = 1'b0; pkt_zlp = 1'b0; pkt_stable = 1'b1; pkt_d1 = 1'b0;
        for (int c = 0; c < 100 && !pkt_got; c++) begin
            tx_ready = (c % 3) != 2;
            if (tx_valid && tx_ready) begin
                if (pkt_len == 0 && !pkt_zlp) pkt_d1 = tx_data1;
                else if (tx_data1 !== pkt_d1) pkt_stable = 1'b0;
                if (tx_zlp) pkt_zlp = 1'b1;
                else if (pkt_len < 64) begin pkt[pkt_len] = tx_data; pkt_len++; end
                if (tx_last) pkt_got = 1'b1;
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic watch(input int n);
        saw_valid = 1'b0; saw_stall = 1'b0; saw_done = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (tx_valid) saw_valid = 1'b1;
            if (stall)    saw_stall = 1'b1;
            if (done)     saw_done  = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; setup_valid = 0; setup_data = '0; in_token = 0; out_status = 0;
        tx_ack = 0; tx_timeout = 0; tx_ready = 0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({tx_valid, tx_last, tx_zlp, tx_data1, stall, busy, done, tx_data, desc_type,
             desc_index, desc_req_len, desc_byte_index} !== '0)
            $display("FAIL reset_outputs: got nonzero outputs valid=%b busy=%b type=%h len=%h idx=%h, want all 0",
                     tx_valid, busy, desc_type, desc_req_len, desc_byte_index);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_device_64();
        int ex_len [3] = '{8, 8, 2};
        logic ex_d1 [3] = '{1'b1, 1'b0, 1'b1};
        do_setup(8'h80, 8'h06, 8'h01, 8'h00, 16'd64);
        total_cnt++;
        if ({busy, desc_type, desc_index, desc_req_len} !== {1'b1, 8'h01, 8'h00, 16'd64})
            $display("FAIL dev64_latch: busy=%b type=%h index=%h len=%0d want 1 01 00 64",
                     busy, desc_type, desc_index, desc_req_len);
        else pass_cnt++;
        for (int p = 0; p < 3; p++) begin
            pulse_in();
            recv_pkt();
            total_cnt++;
            if (!pkt_got || pkt_len != ex_len[p] || pkt_d1 !== ex_d1[p] || pkt_zlp || !pkt_match(8'h01, 8 * p))
                $display("FAIL dev64_pkt%0d: got=%b len=%0d d1=%b zlp=%b data_ok=%b want got=1 len=%0d d1=%b zlp=0 data_ok=1",
                         p, pkt_got, pkt_len, pkt_d1, pkt_zlp, pkt_match(8'h01, 8 * p), ex_len[p], ex_d1[p]);
            else pass_cnt++;
            pulse_ack();
        end
        pulse_in();
        watch(15);
        total_cnt++;
        if (saw_valid !== 1'b0) $display("FAIL dev64_extra_in: tx_valid seen=%b want 0", saw_valid);
        else pass_cnt++;
        pulse_out();
        total_cnt++;
        if (done !== 1'b1) $display("FAIL dev64_done: done=%b want 1", done);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({done, busy} !== 2'b00) $display("FAIL dev64_idle: done=%b busy=%b want 0 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_device_8();
        logic [7:0] exp8 [8] = '{8'h12, 8'h01, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08};
        logic data_ok;
        do_setup(8'h80, 8'h06, 8'h01, 8'h00, 16'd8);
        pulse_in();
        recv_pkt();
        data_ok = 1'b1;
        for (int k = 0; k < 8; k++) if (pkt[k] !== exp8[k]) data_ok = 1'b0;
        total_cnt++;
        if (!pkt_got || pkt_len != 8 || pkt_d1 !== 1'b1 || pkt_zlp || !data_ok)
            $display("FAIL dev8_pkt: got=%b len=%0d d1=%b zlp=%b data_ok=%b want 1 8 1 0 1",
                     pkt_got, pkt_len, pkt_d1, pkt_zlp, data_ok);
        else pass_cnt++;
        pulse_ack();
        pulse_in();
        watch(15);
        total_cnt++;
        if ({saw_valid, busy} !== 2'b01) $display("FAIL dev8_no_zlp: tx_valid seen=%b busy=%b want 0 1", saw_valid, busy);
        else pass_cnt++;
        pulse_out();
        total_cnt++;
        if (done !== 1'b1) $display("FAIL dev8_done: done=%b want 1", done);
        else pass_cnt++;
    endtask

    task automatic test_zlp_16();
        int ex_len [3] = '{8, 8, 0};
        logic ex_d1 [3] = '{1'b1, 1'b0, 1'b1};
        logic ex_zlp [3] = '{1'b0, 1'b0, 1'b1};
        do_setup(8'h80, 8'h06, 8'h03, 8'h00, 16'd64);
        for (int p = 0; p < 3; p++) begin
            pulse_in();
            recv_pkt();
            total_cnt++;
            if (!pkt_got || pkt_len != ex_len[p] || pkt_d1 !== ex_d1[p] || pkt_zlp !== ex_zlp[p] || !pkt_match(8'h03, 8 * p))
                $display("FAIL zlp16_pkt%0d: got=%b len=%0d d1=%b zlp=%b want got=1 len=%0d d1=%b zlp=%b",
                         p, pkt_got, pkt_len, pkt_d1, pkt_zlp, ex_len[p], ex_d1[p], ex_zlp[p]);
            else pass_cnt++;
            pulse_ack();
        end
        pulse_out();
        total_cnt++;
        if (done !== 1'b1) $display("FAIL zlp16_done: done=%b want 1", done);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int ex_start [6] = '{0, 8, 8, 16, 24, 32};
        int ex_len [6] = '{8, 8, 8, 8, 8, 2};
        logic ex_d1 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_setup(8'h81, 8'h06, 8'h02, 8'h00, 16'd255);
        for (int p = 0; p < 6; p++) begin
            pulse_in();
            recv_pkt();
            total_cnt++;
            if (!pkt_got || pkt_len != ex_len[p] || pkt_d1 !== ex_d1[p] || pkt_zlp || !pkt_match(8'h02, ex_start[p]))
                $display("FAIL timeout_pkt%0d: got=%b len=%0d d1=%b zlp=%b first=%h want got=1 len=%0d d1=%b zlp=0 first=%h",
                         p, pkt_got, pkt_len, pkt_d1, pkt_zlp, pkt[0], ex_len[p], ex_d1[p], rom_byte(8'h02, ex_start[p]));
            else pass_cnt++;
            if (p == 1) pulse_timeout();
            else        pulse_ack();
        end
        pulse_out();
        total_cnt++;
        if (done !== 1'b1) $display("FAIL timeout_done: done=%b want 1", done);
        else pass_cnt++;
    endtask

    task automatic test_setup_abort();
        logic found;
        do_setup(8'h80, 8'h06, 8'h01, 8'h00, 16'd64);
        pulse_in();
        recv_pkt();
        pulse_ack();
        pulse_in();
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (tx_valid) found = 1'b1;
            else @(negedge clk);
        end
        total_cnt++;
        if (found !== 1'b1) $display("FAIL abort_reach_send: tx_valid seen=%b want 1", found);
        else pass_cnt++;
        do_setup(8'h80, 8'h06, 8'h01, 8'h00, 16'd64);
        total_cnt++;
        if ({tx_valid, busy} !== 2'b01) $display("FAIL abort_drop: tx_valid=%b busy=%b want 0 1", tx_valid, busy);
        else pass_cnt++;
        pulse_in();
        recv_pkt();
        total_cnt++;
        if (!pkt_got || pkt_len != 8 || pkt_d1 !== 1'b1 || !pkt_match(8'h01, 0))
            $display("FAIL abort_restart: got=%b len=%0d d1=%b first=%h want 1 8 1 12", pkt_got, pkt_len, pkt_d1, pkt[0]);
        else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_unknown();
        do_setup(8'h80, 8'h06, 8'h06, 8'h00, 16'd64);
        pulse_in();
`ifdef USB_DESC_STALL_EN
        watch(20);
        total_cnt++;
        if ({saw_stall, saw_valid, busy} !== 3'b100)
            $display("FAIL unknown_stall: stall=%b tx_valid=%b busy=%b want 1 0 0", saw_stall, saw_valid, busy);
        else pass_cnt++;
`else
        recv_pkt();
        total_cnt++;
        if (!pkt_got || pkt_len != 0 || pkt_zlp !== 1'b1 || pkt_d1 !== 1'b1)
            $display("FAIL unknown_zlp: got=%b len=%0d zlp=%b d1=%b want 1 0 1 1", pkt_got, pkt_len, pkt_zlp, pkt_d1);
        else pass_cnt++;
        pulse_ack();
        pulse_out();
        total_cnt++;
        if (done !== 1'b1) $display("FAIL unknown_done: done=%b want 1", done);
        else pass_cnt++;
`endif
    endtask

    task automatic test_wlen0();
        do_setup(8'h80, 8'h06, 8'h01, 8'h00, 16'd0);
        pulse_in();
        recv_pkt();
        total_cnt++;
        if (!pkt_got || pkt_zlp !== 1'b1 || pkt_d1 !== 1'b1 || pkt_len != 0)
            $display("FAIL wlen0_zlp: got=%b zlp=%b d1=%b len=%0d want 1 1 1 0", pkt_got, pkt_zlp, pkt_d1, pkt_len);
        else pass_cnt++;
        pulse_ack();
        total_cnt++;
        if ({done, busy} !== 2'b10) $display("FAIL wlen0_done: done=%b busy=%b want 1 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_unsupported();
        do_setup(8'h00, 8'h05, 8'h00, 8'h07, 16'd0);
`ifdef USB_DESC_STALL_EN
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL unsup_pending: busy=%b want 1", busy);
        else pass_cnt++;
        pulse_in();
        watch(10);
        total_cnt++;
        if ({saw_stall, saw_valid, busy} !== 3'b100)
            $display("FAIL unsup_stall: stall=%b tx_valid=%b busy=%b want 1 0 0", saw_stall, saw_valid, busy);
        else pass_cnt++;
`else
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL unsup_ignored: busy=%b want 0", busy);
        else pass_cnt++;
        pulse_in();
        watch(10);
        total_cnt++;
        if ({saw_stall, saw_valid, busy} !== 3'b000)
            $display("FAIL unsup_no_data: stall=%b tx_valid=%b busy=%b want 0 0 0", saw_stall, saw_valid, busy);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        logic found;
        do_setup(8'h80, 8'h06, 8'h02, 8'h00, 16'd255);
        pulse_in();
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (tx_valid) found = 1'b1;
            else @(negedge clk);
        end
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({found, tx_valid} !== 2'b10) $display("FAIL rstmid_drop: reached_send=%b tx_valid=%b want 1 0", found, tx_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, stall} !== 3'b000) $display("FAIL rstmid_idle: busy=%b done=%b stall=%b want 0 0 0", busy, done, stall);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_device_64();
        test_device_8();
        test_zlp_16();
        test_timeout();
        test_setup_abort();
        test_unknown();
        test_wlen0();
        test_unsupported();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
